ibex_lsu_lite: RTL and testbench

- Single-outstanding load/store unit that sits between EX and the data bus.
- Produces the LSU response consumed by the writeback stage: resp valid, error, rf write-enable and load data.
- Splits misaligned accesses into two aligned word transactions.
- Handles byte-enable generation, write-data rotation, and load-data alignment with sign or zero extension.

---
 rtl/ibex_lsu_lite.sv | 246 ++++++++++++++++++++++++
 tb/tb_ibex_lsu_lite.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_lsu_lite.sv
`default_nettype none
// ============================================================================
//  Module   : ibex_lsu_lite
//  Purpose  : Single-outstanding load/store unit between EX and the data bus.
//             Splits word-crossing accesses into two aligned bus transactions,
//             generates byte enables, rotates store data and aligns/extends
//             load data for writeback.
//  Revision : 1.0 - initial release
// ============================================================================
module ibex_lsu_lite #(
  parameter bit MisalignedSplit = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_req_done_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_rf_we_o,
  output logic [31:0] lsu_rdata_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        busy_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_GNT1 = 3'd1,
    WAIT_RV1  = 3'd2,
    WAIT_GNT2 = 3'd3,
    WAIT_RV2  = 3'd4,
    ERR       = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [1:0]  type_q;
  logic        sext_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        capture;
  logic        rv1_take;
  logic        fin_err;
  logic        resp_valid;
  logic        req_done;
  logic        bus_req;

  // While IDLE the request is issued straight from EX; afterwards from the captured copy.
  logic        idle;
  logic        cur_we;
  logic [1:0]  cur_type;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  off;
  logic        is_word;
  logic        is_half;
  logic        split;
  logic        second;
  logic [31:0] word_addr;

  assign idle      = (state_q == IDLE);
  assign cur_we    = idle ? lsu_we_i    : we_q;
  assign cur_type  = idle ? lsu_type_i  : type_q;
  assign cur_addr  = idle ? lsu_addr_i  : addr_q;
  assign cur_wdata = idle ? lsu_wdata_i : wdata_q;
  assign off       = cur_addr[1:0];
  assign is_word   = (cur_type == 2'd0);
  assign is_half   = (cur_type == 2'd1);
  // An access is "misaligned" exactly when it crosses a word boundary.
  assign split     = (is_word && (off != 2'd0)) || (is_half && (off == 2'd3));
  assign second    = (state_q == WAIT_GNT2);
  assign word_addr = {cur_addr[31:2], 2'b00};

  // Byte enables and rotated store data for the part currently on the bus.
  logic [3:0]  be;
  logic [31:0] wdata_rot;
  always_comb begin
    be        = 4'b0000;
    wdata_rot = cur_wdata;
    if (second) begin
      if (is_word) begin
        case (off)
          2'd1:    be = 4'b0001;
          2'd2:    be = 4'b0011;
          2'd3:    be = 4'b0111;
          default: be = 4'b0000;
        endcase
      end else begin
        be = 4'b0001;
      end
    end else if (is_word) begin
      be = 4'b1111 << off;
    end else if (is_half) begin
      be = 4'b0011 << off;
    end else begin
      be = 4'b0001 << off;
    end
    case (off)
      2'd1:    wdata_rot = {cur_wdata[23:0], cur_wdata[31:24]};
      2'd2:    wdata_rot = {cur_wdata[15:0], cur_wdata[31:16]};
      2'd3:    wdata_rot = {cur_wdata[7:0],  cur_wdata[31:8]};
      default: wdata_rot = cur_wdata;
    endcase
  end

  // Next state, bus handshake and completion strobes.
  always_comb begin
    state_d    = state_q;
    bus_req    = 1'b0;
    req_done   = 1'b0;
    resp_valid = 1'b0;
    fin_err    = 1'b0;
    capture    = 1'b0;
    rv1_take   = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          capture = 1'b1;
          if (split && !MisalignedSplit) begin
            req_done = 1'b1;
            state_d  = ERR;
          end else begin
            bus_req  = 1'b1;
            req_done = data_gnt_i && !split;
            state_d  = data_gnt_i ? WAIT_RV1 : WAIT_GNT1;
          end
        end
      end
      WAIT_GNT1: begin
        bus_req = 1'b1;
        if (data_gnt_i) begin
          req_done = !split;
          state_d  = WAIT_RV1;
        end
      end
      WAIT_RV1: begin
        if (data_rvalid_i) begin
          rv1_take = 1'b1;
          if (split) begin
            state_d = WAIT_GNT2;
          end else begin
            resp_valid = 1'b1;
            fin_err    = data_err_i;
            state_d    = IDLE;
          end
        end
      end
      WAIT_GNT2: begin
        bus_req = 1'b1;
        if (data_gnt_i) begin
          req_done = 1'b1;
          state_d  = WAIT_RV2;
        end
      end
      WAIT_RV2: begin
        if (data_rvalid_i) begin
          resp_valid = 1'b1;
          fin_err    = err_q | data_err_i;
          state_d    = IDLE;
        end
      end
      ERR: begin
        resp_valid = 1'b1;
        fin_err    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus captured request and first-response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      type_q  <= 2'd0;
      sext_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        we_q    <= lsu_we_i;
        type_q  <= lsu_type_i;
        sext_q  <= lsu_sign_ext_i;
        addr_q  <= lsu_addr_i;
        wdata_q <= lsu_wdata_i;
      end
      if (rv1_take) begin
        rdata_q <= data_rdata_i;
        err_q   <= data_err_i;
      end
    end
  end

  // Load alignment: {r2, r1} shifted right by the byte offset, then extended.
  logic [31:0] r1;
  logic [31:0] aligned;
  always_comb begin
    r1 = (state_q == WAIT_RV2) ? rdata_q : data_rdata_i;
    case (addr_q[1:0])
      2'd1:    aligned = {data_rdata_i[7:0],  r1[31:8]};
      2'd2:    aligned = {data_rdata_i[15:0], r1[31:16]};
      2'd3:    aligned = {data_rdata_i[23:0], r1[31:24]};
      default: aligned = r1;
    endcase
    case (type_q)
      2'd0:    lsu_rdata_o = aligned;
      2'd1:    lsu_rdata_o = {{16{sext_q & aligned[15]}}, aligned[15:0]};
      default: lsu_rdata_o = {{24{sext_q & aligned[7]}}, aligned[7:0]};
    endcase
  end

  assign lsu_req_done_o   = req_done;
  assign lsu_resp_valid_o = resp_valid;
  assign lsu_rf_we_o      = resp_valid & ~we_q & ~fin_err;
  assign load_err_o       = resp_valid & ~we_q &  fin_err;
  assign store_err_o      = resp_valid &  we_q &  fin_err;
  assign busy_o           = !idle;

  assign data_req_o   = bus_req;
  assign data_addr_o  = bus_req ? (second ? word_addr + 32'd4 : word_addr) : 32'd0;
  assign data_we_o    = bus_req & cur_we;
  assign data_be_o    = bus_req ? be : 4'b0000;
  assign data_wdata_o = bus_req ? wdata_rot : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ibex_lsu_lite.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ibex_lsu_lite
//  Purpose  : Self-checking bench for ibex_lsu_lite (table vectors + sequences)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_lsu_lite;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lsu_req_i, req0, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;

  logic        lsu_req_done_o, lsu_resp_valid_o, lsu_rf_we_o, load_err_o, store_err_o, busy_o;
  logic [31:0] lsu_rdata_o, data_addr_o, data_wdata_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;

  logic        d0_req_done, d0_resp_valid, d0_rf_we, d0_load_err, d0_store_err, d0_busy;
  logic [31:0] d0_rdata, d0_addr, d0_wdata;
  logic        d0_req, d0_we;
  logic [3:0]  d0_be;

  always #5 clk_i = ~clk_i;

  ibex_lsu_lite #(.MisalignedSplit(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_req_done_o(lsu_req_done_o), .lsu_resp_valid_o(lsu_resp_valid_o),
    .lsu_rf_we_o(lsu_rf_we_o), .lsu_rdata_o(lsu_rdata_o), .load_err_o(load_err_o),
    .store_err_o(store_err_o), .busy_o(busy_o), .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  ibex_lsu_lite #(.MisalignedSplit(1'b0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_req_i(req0), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_req_done_o(d0_req_done), .lsu_resp_valid_o(d0_resp_valid),
    .lsu_rf_we_o(d0_rf_we), .lsu_rdata_o(d0_rdata), .load_err_o(d0_load_err),
    .store_err_o(d0_store_err), .busy_o(d0_busy), .data_req_o(d0_req),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_addr_o(d0_addr), .data_we_o(d0_we), .data_be_o(d0_be),
    .data_wdata_o(d0_wdata), .data_rdata_i(data_rdata_i)
  );

  typedef struct {
    logic        we;
    logic [1:0]  typ;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        split;
    int          gdly;
    int          rvdly;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd;
    logic [31:0] a2;
    logic [3:0]  be2;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        e1;
    logic        e2;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [1:0] typ, input logic sext, input logic [31:0] addr,
    input logic [31:0] wdata, input logic split, input int gdly, input int rvdly,
    input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd,
    input logic [31:0] a2, input logic [3:0] be2, input logic [31:0] r1,
    input logic [31:0] r2, input logic e1, input logic e2,
    input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.typ = typ; v.sext = sext; v.addr = addr; v.wdata = wdata;
    v.split = split; v.gdly = gdly; v.rvdly = rvdly; v.a1 = a1; v.be1 = be1;
    v.wd = wd; v.a2 = a2; v.be2 = be2; v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Response scoreboard: pop one expected response for every resp_valid pulse.
  always @(negedge clk_i) begin
    resp_t e;
    #2;
    if (rst_ni && lsu_resp_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rf_we",     32'(lsu_rf_we_o), 32'(!e.we && !e.err));
        chk("load_err",  32'(load_err_o),  32'(!e.we && e.err));
        chk("store_err", 32'(store_err_o), 32'(e.we && e.err));
        if (!e.we && !e.err) chk("rdata", lsu_rdata_o, e.rdata);
      end
    end
  end

  task automatic idle_inputs();
    lsu_req_i = 1'b0; req0 = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    data_err_i = 1'b0; data_rdata_i = 32'd0;
  endtask

  // Drives one access and plays the bus side, checking each request cycle.
  task automatic run_vec(input vec_t v);
    int   ndone;
    int   nparts;
    logic last;
    ndone  = 0;
    nparts = v.split ? 2 : 1;
    sb.push_back('{we: v.we, rdata: v.exp_rdata, err: v.exp_err});
    for (int part = 0; part < nparts; part++) begin
      last = (part == nparts - 1);
      for (int k = 0; k <= v.gdly; k++) begin
        @(negedge clk_i);
        lsu_req_i = (part == 0 && k == 0);
        if (part == 0 && k == 0) begin
          lsu_we_i = v.we; lsu_type_i = v.typ; lsu_sign_ext_i = v.sext;
          lsu_addr_i = v.addr; lsu_wdata_i = v.wdata;
        end else begin
          lsu_addr_i = 32'hFFFF_FFF0; lsu_wdata_i = 32'h5A5A_5A5A;
        end
        data_gnt_i = (k == v.gdly);
        data_rvalid_i = 1'b0;
        #1;
        chk("data_req",   32'(data_req_o), 32'd1);
        chk("data_addr",  data_addr_o, (part == 0) ? v.a1 : v.a2);
        chk("data_be",    32'(data_be_o), 32'((part == 0) ? v.be1 : v.be2));
        chk("data_wdata", data_wdata_o, v.wd);
        chk("data_we",    32'(data_we_o), 32'(v.we));
        chk("req_done",   32'(lsu_req_done_o), 32'(data_gnt_i && last));
        if (lsu_req_done_o) ndone++;
      end
      for (int k = 1; k <= v.rvdly; k++) begin
        @(negedge clk_i);
        lsu_req_i = 1'b0; data_gnt_i = 1'b0;
        data_rvalid_i = (k == v.rvdly);
        data_rdata_i  = (part == 0) ? v.r1 : v.r2;
        data_err_i    = (part == 0) ? v.e1 : v.e2;
        #1;
        chk("req_in_rv",  32'(data_req_o), 32'd0);
        chk("busy_in_rv", 32'(busy_o), 32'd1);
      end
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    chk("busy_after",    32'(busy_o), 32'd0);
    chk("resp_after",    32'(lsu_resp_valid_o), 32'd0);
    chk("resp_seen",     32'(sb.size()), 32'd0);
    chk("req_done_once", 32'(ndone), 32'd1);
  endtask

  vec_t tbl[11];
  vec_t spl[5];

  initial begin
    tbl[0]  = mk(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 1'b0, 0, 2, 32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    tbl[1]  = mk(1'b0, 2'd2, 1'b1, 32'h103, 32'h0, 1'b0, 1, 1, 32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h80FFFFFF, 32'h0, 1'b0, 1'b0, 32'hFFFFFF80, 1'b0);
    tbl[2]  = mk(1'b0, 2'd2, 1'b0, 32'h103, 32'h0, 1'b0, 1, 1, 32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h80FFFFFF, 32'h0, 1'b0, 1'b0, 32'h00000080, 1'b0);
    tbl[3]  = mk(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1'b0, 0, 1, 32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h80011234, 32'h0, 1'b0, 1'b0, 32'hFFFF8001, 1'b0);
    tbl[4]  = mk(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 1'b0, 2, 1, 32'h100, 4'h6, 32'h0, 32'h0, 4'h0, 32'h00ABCD00, 32'h0, 1'b0, 1'b0, 32'h0000ABCD, 1'b0);
    tbl[5]  = mk(1'b1, 2'd2, 1'b0, 32'h302, 32'hA5, 1'b0, 2, 1, 32'h300, 4'h4, 32'h00A50000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tbl[6]  = mk(1'b1, 2'd1, 1'b0, 32'h400, 32'h0000BEEF, 1'b0, 0, 3, 32'h400, 4'h3, 32'h0000BEEF, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tbl[7]  = mk(1'b1, 2'd0, 1'b0, 32'h500, 32'h12345678, 1'b0, 1, 1, 32'h500, 4'hF, 32'h12345678, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tbl[8]  = mk(1'b0, 2'd0, 1'b0, 32'h504, 32'h0, 1'b0, 0, 1, 32'h504, 4'hF, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tbl[9]  = mk(1'b0, 2'd3, 1'b1, 32'h101, 32'h0, 1'b0, 0, 1, 32'h100, 4'h2, 32'h0, 32'h0, 4'h0, 32'h00007F00, 32'h0, 1'b0, 1'b0, 32'h0000007F, 1'b0);
    tbl[10] = mk(1'b0, 2'd2, 1'b1, 32'h100, 32'h0, 1'b0, 0, 1, 32'h100, 4'h1, 32'h0, 32'h0, 4'h0, 32'h12345699, 32'h0, 1'b0, 1'b0, 32'hFFFFFF99, 1'b0);

    spl[0] = mk(1'b1, 2'd0, 1'b0, 32'h201, 32'h11223344, 1'b1, 3, 1, 32'h200, 4'hE, 32'h22334411, 32'h204, 4'h1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    spl[1] = mk(1'b0, 2'd1, 1'b1, 32'h2FF, 32'h0, 1'b1, 0, 1, 32'h2FC, 4'h8, 32'h0, 32'h300, 4'h1, 32'hAB000000, 32'h000000CD, 1'b0, 1'b0, 32'hFFFFCDAB, 1'b0);
    spl[2] = mk(1'b0, 2'd0, 1'b0, 32'h602, 32'h0, 1'b1, 1, 2, 32'h600, 4'hC, 32'h0, 32'h604, 4'h3, 32'h55667788, 32'h11223344, 1'b1, 1'b0, 32'h0, 1'b1);
    spl[3] = mk(1'b0, 2'd0, 1'b0, 32'h703, 32'h0, 1'b1, 0, 1, 32'h700, 4'h8, 32'h0, 32'h704, 4'h7, 32'hAABBCCDD, 32'h11223344, 1'b0, 1'b0, 32'h223344AA, 1'b0);
    spl[4] = mk(1'b0, 2'd0, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b1, 0, 1, 32'hFFFFFFFC, 4'hC, 32'h0, 32'h0, 4'h3, 32'h12340000, 32'h00005678, 1'b0, 1'b0, 32'h56781234, 1'b0);

    rst_ni = 1'b0;
    lsu_we_i = 1'b0; lsu_type_i = 2'd0; lsu_sign_ext_i = 1'b0;
    lsu_addr_i = 32'd0; lsu_wdata_i = 32'd0;
    idle_inputs();

    // Reset state
    @(negedge clk_i); #1;
    chk("rst_busy",       32'(busy_o), 32'd0);
    chk("rst_data_req",   32'(data_req_o), 32'd0);
    chk("rst_resp_valid", 32'(lsu_resp_valid_o), 32'd0);
    chk("rst_req_done",   32'(lsu_req_done_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Stray rvalid while idle must not produce a response
    @(negedge clk_i);
    data_rvalid_i = 1'b1;
    #1;
    chk("stray_rvalid_resp", 32'(lsu_resp_valid_o), 32'd0);
    @(negedge clk_i);
    idle_inputs();

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);
    for (int i = 0; i < 5; i++) run_vec(spl[i]);

    // Rejection of a word-crossing access when splitting is disabled
    @(negedge clk_i);
    req0 = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'd0; lsu_addr_i = 32'h2; data_gnt_i = 1'b1;
    #1;
    chk("rej_data_req",   32'(d0_req), 32'd0);
    chk("rej_req_done",   32'(d0_req_done), 32'd1);
    chk("rej_resp_early", 32'(d0_resp_valid), 32'd0);
    @(negedge clk_i);
    idle_inputs();
    #1;
    chk("rej_resp_valid", 32'(d0_resp_valid), 32'd1);
    chk("rej_load_err",   32'(d0_load_err), 32'd1);
    chk("rej_rf_we",      32'(d0_rf_we), 32'd0);
    chk("rej_store_err",  32'(d0_store_err), 32'd0);
    chk("rej_no_req",     32'(d0_req), 32'd0);
    @(negedge clk_i); #1;
    chk("rej_resp_end",   32'(d0_resp_valid), 32'd0);
    chk("rej_busy_end",   32'(d0_busy), 32'd0);

    // Reset while waiting for the first response
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'd0; lsu_addr_i = 32'h800; data_gnt_i = 1'b1;
    @(negedge clk_i);
    idle_inputs();
    #1;
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy",     32'(busy_o), 32'd0);
    chk("mid_rst_data_req", 32'(data_req_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i); #1;
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    // Aligned access works normally after the mid-operation reset
    run_vec(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
